ram_stream_reader: RTL and testbench

RAM_STREAM_READER -- requirements
Module: ram_stream_reader

---
 rtl/ram_stream_reader_pkg.sv | 27 ++
 rtl/ram_stream_reader_if.sv | 29 ++
 rtl/ram_stream_reader_skid_fifo2.sv | 96 +++++++++
 rtl/ram_stream_reader.sv | 161 ++++++++++++++++
 tb/tb_ram_stream_reader.sv | 182 ++++++++++++++++++
 5 files changed

// File: rtl/ram_stream_reader_pkg.sv
// Shared memory-block header: the address-width helper and the reader FSM
// state encodings. Imported by the reader top and its testbench.
package ram_stream_reader_pkg;

  // Reader control states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  // Number of bits needed to hold 'value' (at least one bit).
  // Given SIZE-1, this is the width of a RAM address, and it also works
  // when SIZE is not a power of two.
  function automatic int clog2(input int value);
    int bits_v;
    int rem_v;
    bits_v = 32'sd1;
    rem_v  = value >>> 32'd1;
    while (rem_v > 32'sd0) begin
      bits_v = bits_v + 32'sd1;
      rem_v  = rem_v >>> 32'd1;
    end
    return bits_v;
  endfunction

endpackage

// File: rtl/ram_stream_reader_if.sv
// Output stream bundle of the RAM stream reader (AXI-stream style).
//   m_valid : beat valid           (master -> slave)
//   m_ready : downstream accept    (slave  -> master)
//   m_data  : beat data, WIDTH     (master -> slave)
//   m_last  : final beat marker    (master -> slave)
interface ram_stream_reader_if #(
  parameter int WIDTH = 32
);

  logic             m_valid;
  logic             m_ready;
  logic [WIDTH-1:0] m_data;
  logic             m_last;

  modport master (
    output m_valid,
    output m_data,
    output m_last,
    input  m_ready
  );

  modport slave (
    input  m_valid,
    input  m_data,
    input  m_last,
    output m_ready
  );

endinterface

// File: rtl/ram_stream_reader_skid_fifo2.sv
// Two-entry FIFO that buffers RAM read data in front of the output stream.
// The head entry is always held in mem0_r, so head data and valid come
// straight from registers and stay stable until a pop.
//   clk, rst   : clock, synchronous active-high reset
//   push       : write push_data this cycle
//   push_data  : WIDTH-bit entry to write
//   pop        : remove the head entry (ignored when empty)
//   head_data  : current head entry
//   head_valid : FIFO is not empty
//   count      : number of stored entries, 0..2
module skid_fifo2 #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             head_valid,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] mem0_r;
  logic [WIDTH-1:0] mem1_r;
  logic [1:0]       count_r;
  logic             valid_r;
  logic             pop_ok_s;
  logic             push_ok_s;

  // Qualify pop against empty and push against full.
  always_comb begin
    pop_ok_s  = 1'b0;
    push_ok_s = 1'b0;
    if (pop && valid_r) begin
      pop_ok_s = 1'b1;
    end else begin
      pop_ok_s = 1'b0;
    end
    if (push && ((count_r != 2'd2) || pop_ok_s)) begin
      push_ok_s = 1'b1;
    end else begin
      push_ok_s = 1'b0;
    end
  end

  // Storage, occupancy and valid flag update.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem0_r  <= '0;
      mem1_r  <= '0;
      count_r <= 2'd0;
      valid_r <= 1'b0;
    end else begin
      case ({push_ok_s, pop_ok_s})
        2'b10: begin
          if (count_r == 2'd0) begin
            mem0_r <= push_data;
          end else begin
            mem1_r <= push_data;
          end
          count_r <= count_r + 2'd1;
          valid_r <= 1'b1;
        end
        2'b01: begin
          // Only shift when a second entry exists; an emptied head keeps
          // its last value.
          if (count_r == 2'd2) begin
            mem0_r <= mem1_r;
          end else begin
            mem0_r <= mem0_r;
          end
          count_r <= count_r - 2'd1;
          valid_r <= (count_r == 2'd2);
        end
        2'b11: begin
          if (count_r == 2'd1) begin
            mem0_r <= push_data;
          end else begin
            mem0_r <= mem1_r;
            mem1_r <= push_data;
          end
        end
        default: begin
          count_r <= count_r;
          valid_r <= valid_r;
        end
      endcase
    end
  end

  assign head_data  = mem0_r;
  assign head_valid = valid_r;
  assign count      = count_r;

endmodule

// File: rtl/ram_stream_reader.sv
// Streams a block of words out of a single-port RAM with registered read
// data. A transfer starts at 'base' and reads 'len' words, wrapping modulo
// SIZE, and presents them as an AXI-stream style output. A 2-entry FIFO
// absorbs the one-cycle RAM latency so the stream can run at one beat per
// cycle while never dropping or duplicating a word under back-pressure.
//   clk, rst       : clock, synchronous active-high reset
//   start          : one-cycle request, sampled only in IDLE
//   base, len      : first address and word count (0..SIZE), sampled with start
//   ram_en_read    : RAM read enable
//   ram_addr_read  : RAM read address (holds when no read is issued)
//   ram_data_out   : RAM read data, valid the cycle after ram_en_read
//   m_if           : output stream (m_valid/m_ready/m_data/m_last)
//   busy           : high outside IDLE
//   done           : one-cycle pulse after the last beat is accepted
module ram_stream_reader
  import ram_stream_reader_pkg::*;
#(
  parameter  int SIZE  = 64,
  parameter  int WIDTH = 32,
  localparam int AW    = clog2(SIZE - 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [AW-1:0]       base,
  input  logic [AW:0]         len,
  output logic                ram_en_read,
  output logic [AW-1:0]       ram_addr_read,
  input  logic [WIDTH-1:0]    ram_data_out,
  ram_stream_reader_if.master m_if,
  output logic                busy,
  output logic                done
);

  localparam logic [AW-1:0] ADDR_ONE  = AW'(32'd1);
  localparam logic [AW-1:0] ADDR_LAST = AW'(SIZE - 1);
  localparam logic [AW:0]   LEN_ONE   = (AW + 1)'(32'd1);

  state_e           state_r;
  logic [AW-1:0]    addr_r;
  logic [AW:0]      remaining_r;
  logic             inflight_r;
  logic             inflight_last_r;
  logic             busy_r;
  logic             done_r;

  logic             issue_s;
  logic             last_issue_s;
  logic             pop_s;
  logic [2:0]       occ_s;
  logic [AW-1:0]    next_addr_s;
  logic [1:0]       fifo_count_s;
  logic             fifo_valid_s;
  logic [WIDTH:0]   fifo_head_s;

  // Read issue decision, next address and accept qualification.
  always_comb begin
    pop_s = fifo_valid_s & m_if.m_ready;
    // Words the FIFO will hold after this edge; a read issued now lands
    // one cycle later, so it is safe only while this stays below two.
    occ_s = {1'b0, fifo_count_s} + {2'b00, inflight_r} - {2'b00, pop_s};
    if (!rst && (state_r == ST_RUN) && (remaining_r != '0) && (occ_s < 3'd2)) begin
      issue_s = 1'b1;
    end else begin
      issue_s = 1'b0;
    end
    if (issue_s && (remaining_r == LEN_ONE)) begin
      last_issue_s = 1'b1;
    end else begin
      last_issue_s = 1'b0;
    end
    if (addr_r == ADDR_LAST) begin
      next_addr_s = '0;
    end else begin
      next_addr_s = addr_r + ADDR_ONE;
    end
  end

  // Control FSM with its registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r         <= ST_IDLE;
      addr_r          <= '0;
      remaining_r     <= '0;
      inflight_r      <= 1'b0;
      inflight_last_r <= 1'b0;
      busy_r          <= 1'b0;
      done_r          <= 1'b0;
    end else begin
      // The last-word flag travels with the read so it lands in the FIFO
      // beside its data.
      inflight_r      <= issue_s;
      inflight_last_r <= last_issue_s;
      done_r          <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            if (len != '0) begin
              state_r     <= ST_RUN;
              busy_r      <= 1'b1;
              addr_r      <= base;
              remaining_r <= len;
            end else begin
              done_r <= 1'b1;
            end
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_RUN: begin
          if (issue_s) begin
            addr_r      <= next_addr_s;
            remaining_r <= remaining_r - LEN_ONE;
            if (remaining_r == LEN_ONE) begin
              state_r <= ST_DRAIN;
            end else begin
              state_r <= ST_RUN;
            end
          end else begin
            state_r <= ST_RUN;
          end
        end
        ST_DRAIN: begin
          if (pop_s && fifo_head_s[WIDTH]) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
          end else begin
            state_r <= ST_DRAIN;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  skid_fifo2 #(
    .WIDTH (WIDTH + 1)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (inflight_r),
    .push_data  ({inflight_last_r, ram_data_out}),
    .pop        (pop_s),
    .head_data  (fifo_head_s),
    .head_valid (fifo_valid_s),
    .count      (fifo_count_s)
  );

  assign ram_en_read   = issue_s;
  assign ram_addr_read = addr_r;
  assign busy          = busy_r;
  assign done          = done_r;
  assign m_if.m_valid  = fifo_valid_s;
  assign m_if.m_data   = fifo_head_s[WIDTH-1:0];
  assign m_if.m_last   = fifo_head_s[WIDTH];

endmodule

// File: tb/tb_ram_stream_reader.sv
// Directed testbench for ram_stream_reader with a registered-read RAM model
// preloaded with Mem[i] = i.
module tb_ram_stream_reader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [5:0]  base;
  logic [6:0]  len;
  logic        ram_en_read;
  logic [5:0]  ram_addr_read;
  logic [31:0] ram_data_out;
  logic        busy;
  logic        done;
  logic [31:0] mem [64];

  int checks = 0;
  int errors = 0;

  ram_stream_reader_if #(.WIDTH(32)) s_if ();

  ram_stream_reader #(
    .SIZE  (64),
    .WIDTH (32)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .base          (base),
    .len           (len),
    .ram_en_read   (ram_en_read),
    .ram_addr_read (ram_addr_read),
    .ram_data_out  (ram_data_out),
    .m_if          (s_if),
    .busy          (busy),
    .done          (done)
  );

  always #5 clk = ~clk;

  // Single-port RAM model with registered read data.
  always @(posedge clk) begin
    if (ram_en_read) ram_data_out <= mem[ram_addr_read];
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic ready_for(input int mode, input int k);
    if (mode == 0) return 1'b1;
    return ((k % 3) == 0);
  endfunction

  // One transfer from start (cycle k=0) to done. exp_done<0 means done must
  // follow the last accepted beat by one cycle. restart_k>0 pulses a second
  // start with different base/len in that cycle.
  task automatic run_xfer(input string tag, input logic [5:0] b, input logic [6:0] n,
                          input int mode, input int exp_done, input int restart_k);
    int idx = 0, done_k = -1, first_en = -1, first_val = -1, last_acc = -1, en_cnt = 0;
    logic prev_en = 1'b0, prev_stall = 1'b0, held_last = 1'b0;
    logic [31:0] held_data = 32'd0;
    logic [5:0]  prev_addr;
    prev_addr = ram_addr_read;
    start = 1'b1; base = b; len = n; s_if.m_ready = ready_for(mode, 0);
    for (int k = 0; k < 200 && done_k < 0; k++) begin
      @(negedge clk);
      if (ram_en_read) begin
        en_cnt++;
        if (first_en < 0) first_en = k;
      end
      if (!ram_en_read && !prev_en) check({tag, "_addr_hold"}, ram_addr_read, prev_addr);
      if (s_if.m_valid && first_val < 0) first_val = k;
      if (prev_stall) begin
        check({tag, "_stall_valid"}, s_if.m_valid, 1'b1);
        check({tag, "_stall_data"}, s_if.m_data, held_data);
        check({tag, "_stall_last"}, s_if.m_last, held_last);
      end
      if (mode == 1) check({tag, "_fifo_le2"}, (dut.u_fifo.count_r <= 2'd2), 1'b1);
      if (s_if.m_valid && s_if.m_ready) begin
        check({tag, "_data"}, s_if.m_data, 32'((int'(b) + idx) % 64));
        check({tag, "_last"}, s_if.m_last, (idx == int'(n) - 1));
        idx++;
        last_acc = k;
      end
      if (done) done_k = k;
      prev_stall = s_if.m_valid && !s_if.m_ready;
      held_data  = s_if.m_data;
      held_last  = s_if.m_last;
      prev_en    = ram_en_read;
      prev_addr  = ram_addr_read;
      @(posedge clk); #1;
      start = (k + 1 == restart_k);
      if (k + 1 == restart_k) begin
        base = b + 6'd9;
        len  = 7'd2;
      end
      s_if.m_ready = ready_for(mode, k + 1);
    end
    start = 1'b0;
    s_if.m_ready = 1'b1;
    check({tag, "_done_seen"}, (done_k >= 0), 1'b1);
    check({tag, "_beats"}, idx, int'(n));
    check({tag, "_reads"}, en_cnt, int'(n));
    if (n != 7'd0) begin
      check({tag, "_first_en"}, first_en, 1);
      check({tag, "_first_valid"}, first_val, 3);
    end else begin
      check({tag, "_no_valid"}, (first_val < 0), 1'b1);
    end
    if (exp_done >= 0) check({tag, "_done_cycle"}, done_k, exp_done);
    else               check({tag, "_done_after_last"}, done_k, last_acc + 1);
    @(negedge clk);
    check({tag, "_done_pulse"}, done, 1'b0);
    check({tag, "_idle_busy"}, busy, 1'b0);
    @(posedge clk); #1;
  endtask

  initial begin
    int beats;
    for (int i = 0; i < 64; i++) mem[i] = 32'(i);
    ram_data_out = 32'd0;
    rst = 1'b1; start = 1'b0; base = 6'd0; len = 7'd0; s_if.m_ready = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    @(negedge clk);
    check("rst_valid", s_if.m_valid, 1'b0);
    check("rst_last", s_if.m_last, 1'b0);
    check("rst_data", s_if.m_data, 32'd0);
    check("rst_en", ram_en_read, 1'b0);
    check("rst_addr", ram_addr_read, 6'd0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    run_xfer("b5_l4", 6'd5, 7'd4, 0, 7, 0);
    run_xfer("wrap", 6'd62, 7'd4, 0, 7, 0);
    run_xfer("stall", 6'd0, 7'd10, 1, -1, 0);
    run_xfer("len0", 6'd3, 7'd0, 0, 1, 0);
    run_xfer("restart", 6'd20, 7'd8, 0, 11, 3);

    // Reset after the third beat of a len=8 transfer.
    beats = 0;
    start = 1'b1; base = 6'd30; len = 7'd8; s_if.m_ready = 1'b1;
    for (int k = 0; k < 20 && beats < 3; k++) begin
      @(negedge clk);
      if (s_if.m_valid && s_if.m_ready) begin
        check("abort_data", s_if.m_data, 32'(30 + beats));
        beats++;
      end
      @(posedge clk); #1;
      start = 1'b0;
    end
    check("abort_beats", beats, 3);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("abort_valid", s_if.m_valid, 1'b0);
    check("abort_busy", busy, 1'b0);
    check("abort_done", done, 1'b0);
    check("abort_en", ram_en_read, 1'b0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("abort_quiet_done", done, 1'b0);
      check("abort_quiet_valid", s_if.m_valid, 1'b0);
    end
    @(posedge clk); #1;
    run_xfer("post_rst", 6'd0, 7'd2, 0, 5, 0);

    run_xfer("full", 6'd17, 7'd64, 0, 67, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
